fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 9-bit pipelined CPU. It owns the program counter, addresses the instruction ROM, and presents one registered 9-bit instruction per cycle to the decode-stage control unit. It accepts branch/jump redirects from execute, stalls from hazard logic, and halt from decode. It sequences program start/halt and counts execution cycles.

## Interface
- PC_WIDTH, 8, program counter / ROM address width
- INSTR_WIDTH, 9, instruction width (opcode [8:4], operands [3:0])
- CNT_WIDTH, 16, cycle counter width

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  level; begin program from address 0 when IDLE/HALTED
- halt_dec  in  1  decode has a halt instruction in IF/ID
- stall  in  1  hold PC and IF/ID (hazard)
- branch_taken  in  1  execute resolved a taken branch/jump
- branch_target  in  PC_WIDTH  redirect address
- imem_addr  out  PC_WIDTH  ROM address (= PC, combinational)
- imem_data  in  INSTR_WIDTH  ROM read data, combinational w.r.t. imem_addr
- instr_out  out  INSTR_WIDTH  IF/ID instruction to control unit
- pc_out  out  PC_WIDTH  address of instr_out
- instr_valid  out  1  instr_out is real (not bubble)
- halted  out  1  program finished
- cycle_count  out  CNT_WIDTH  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- IDLE/HALTED: PC held at 0 (HALTED: PC reset to 0 on entry), IF/ID holds BUBBLE (9'b11011_0000), instr_valid=0. start=1 → RUN next cycle, halted cleared, cycle_count cleared to 0.
- RUN, per cycle, priority highest first:
  1. branch_taken: PC ← branch_target; IF/ID ← BUBBLE, valid=0. Overrides stall and halt_dec (older instruction wins).
  2. stall: PC, instr_out, pc_out, instr_valid all held.
  3. halt_dec: → HALTED; IF/ID ← BUBBLE; halted=1 from next cycle.
  4. else: instr_out ← imem_data, pc_out ← PC, valid=1, PC ← PC+1.
- PC increment modulo 2^PC_WIDTH (255→0), no flag.
- start ignored while in RUN.
- cycle_count increments every RUN cycle (including stall/flush), saturates at all-ones, holds in HALTED until next start.

## Timing
- Reset values: PC=0, instr_out=BUBBLE, pc_out=0, instr_valid=0, halted=0, cycle_count=0, state IDLE. Asynchronous assert; state changes on rising clk after rst_n deasserts.
- Fetch latency: instruction at address A on instr_out 1 cycle after PC=A.
- Start: start high at edge N → first ROM read at PC=0 during cycle N+1; instruction 0 on instr_out after edge N+2.
- Branch: branch_taken at edge N → imem_addr=target during cycle N+1, instr_out=BUBBLE during N+1; target instruction valid after edge N+2. One-bubble penalty from this stage.
- Halt: halt_dec at edge N (no stall/branch) → halted=1 and instr_valid=0 after N.
- Reset mid-RUN: all state to reset values immediately; restart requires start.

## Structure
- Shared package cpu_pkg: INSTR_WIDTH, opcode constants (halt=5'b11010, jump=5'b11000), BUBBLE, fetch state enum.
- One sub-module natural: sat_counter (CNT_WIDTH, enable, clear, saturate) for cycle_count. PC/IF-ID logic inline.

## Test plan
- Reset then start pulse, ROM[0..3]=0x001,0x012,0x023,0x034 → instr_out 0x001,0x012,0x023,0x034 on consecutive cycles, pc_out 0..3, valid=1.
- branch_taken with target 0x40 at PC=5 → next cycle imem_addr=0x40, instr_out=BUBBLE valid=0; following cycle instr_out=ROM[0x40], pc_out=0x40.
- stall held 3 cycles at PC=7 → PC, instr_out, pc_out unchanged for 3 cycles; resumes with ROM[7]; cycle_count advances by 3.
- halt_dec and branch_taken same cycle → branch taken, no halt; halt_dec alone → halted=1, valid=0, then start → fetch restarts at 0, cycle_count=0.
- PC wrap: linear fetch from 0xFE → pc_out 0xFE,0xFF,0x00; rst_n low mid-RUN → all outputs reset values asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit pipelined CPU: instruction format,
// opcodes that the front end cares about, and the fetch sequencer states.
package cpu_pkg;

  localparam int INSTR_WIDTH = 9;
  localparam int OPC_WIDTH   = 5;

  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 5'b11010;
  localparam logic [OPC_WIDTH-1:0] OPC_JUMP = 5'b11000;
  localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 5'b11011;

  // Bubble injected into IF/ID on flush, idle and halt; decodes as a no-op.
  localparam logic [INSTR_WIDTH-1:0] BUBBLE = {OPC_NOP, 4'b0000};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, sequences start/halt,
// and applies redirect > stall > halt > normal fetch priority while running.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt_dec,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  fetch_state_e        state;
  logic [PC_WIDTH-1:0] pc;
  logic                cnt_clear;
  logic                cnt_enable;

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_out   <= BUBBLE;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          pc          <= '0;
          instr_out   <= BUBBLE;
          instr_valid <= 1'b0;
          if (start) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        S_RUN: begin
          // A taken branch is older than whatever sits in IF/ID, so it beats stall and halt.
          if (branch_taken) begin
            pc          <= branch_target;
            instr_out   <= BUBBLE;
            instr_valid <= 1'b0;
          end else if (stall) begin
            pc <= pc;
          end else if (halt_dec) begin
            state       <= S_HALTED;
            halted      <= 1'b1;
            pc          <= '0;
            instr_out   <= BUBBLE;
            instr_valid <= 1'b0;
          end else begin
            instr_out   <= imem_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_WIDTH'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Counter restarts on the start that leaves IDLE/HALTED, then counts every RUN cycle.
  assign cnt_clear  = (state != S_RUN) && start;
  assign cnt_enable = (state == S_RUN);

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level reference model of the
// fetch rules and a per-cycle compare process, plus literal spot checks.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int PC_WIDTH  = 8;
  localparam int CNT_WIDTH = 16;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic                   halt_dec;
  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   instr_valid;
  logic                   halted;
  logic [CNT_WIDTH-1:0]   cycle_count;

  logic [INSTR_WIDTH-1:0] rom [256];

  int tests_run;
  int tests_failed;
  bit check_en;

  // Reference model state: "running" flag, PC and IF/ID contents as plain integers.
  bit m_running;
  bit m_halted;
  bit m_valid;
  int m_pc;
  int m_pc_out;
  int m_instr;
  int m_count;

  fetch_stage #(
    .PC_WIDTH (PC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt_dec     (halt_dec),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .cycle_count  (cycle_count)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit h, input bit st, input bit b, input int tgt);
    start         = s;
    halt_dec      = h;
    stall         = st;
    branch_taken  = b;
    branch_target = PC_WIDTH'(tgt);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 1'b0;
      m_halted  = 1'b0;
      m_valid   = 1'b0;
      m_pc      = 0;
      m_pc_out  = 0;
      m_instr   = int'(BUBBLE);
      m_count   = 0;
    end else if (!m_running) begin
      if (start) begin
        m_running = 1'b1;
        m_halted  = 1'b0;
        m_count   = 0;
      end
    end else begin
      m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      if (branch_taken) begin
        m_pc    = int'(branch_target);
        m_instr = int'(BUBBLE);
        m_valid = 1'b0;
      end else if (!stall) begin
        if (halt_dec) begin
          m_running = 1'b0;
          m_halted  = 1'b1;
          m_pc      = 0;
          m_instr   = int'(BUBBLE);
          m_valid   = 1'b0;
        end else begin
          m_instr  = int'(rom[m_pc]);
          m_pc_out = m_pc;
          m_valid  = 1'b1;
          m_pc     = (m_pc + 1) % 256;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model imem_addr", int'(imem_addr), m_pc);
      checkOutput("model instr_out", int'(instr_out), m_instr);
      checkOutput("model instr_valid", int'(instr_valid), int'(m_valid));
      checkOutput("model halted", int'(halted), int'(m_halted));
      checkOutput("model cycle_count", int'(cycle_count), m_count);
      if (m_valid) checkOutput("model pc_out", int'(pc_out), m_pc_out);
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    check_en     = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = INSTR_WIDTH'((1 + 17 * i) % 512);
    start = 1'b0; halt_dec = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    rst_n = 1'b0;

    #7;
    checkOutput("reset instr_out", int'(instr_out), 9'h1B0);
    checkOutput("reset pc_out", int'(pc_out), 0);
    checkOutput("reset valid", int'(instr_valid), 0);
    checkOutput("reset halted", int'(halted), 0);
    checkOutput("reset cycle_count", int'(cycle_count), 0);
    checkOutput("reset imem_addr", int'(imem_addr), 0);

    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle valid", int'(instr_valid), 0);

    // Start and linear fetch of ROM[0..4].
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("start imem_addr", int'(imem_addr), 0);
    checkOutput("start valid", int'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fetch0 instr", int'(instr_out), 9'h001);
    checkOutput("fetch0 pc_out", int'(pc_out), 0);
    checkOutput("fetch0 valid", int'(instr_valid), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fetch1 instr", int'(instr_out), 9'h012);
    checkOutput("fetch1 pc_out", int'(pc_out), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fetch2 instr", int'(instr_out), 9'h023);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fetch3 instr", int'(instr_out), 9'h034);
    checkOutput("fetch3 pc_out", int'(pc_out), 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pc before branch", int'(imem_addr), 5);

    // Branch to 0x40 from PC=5: one bubble, then target instruction.
    applyStimulus(0, 0, 0, 1, 8'h40);
    checkOutput("branch imem_addr", int'(imem_addr), 8'h40);
    checkOutput("branch bubble", int'(instr_out), 9'h1B0);
    checkOutput("branch valid", int'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("target instr", int'(instr_out), 9'h041);
    checkOutput("target pc_out", int'(pc_out), 8'h40);

    // Redirect to 7 and stall there for three cycles.
    applyStimulus(0, 0, 0, 1, 7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("stall imem_addr", int'(imem_addr), 7);
    end
    checkOutput("stall cycle_count", int'(cycle_count), 11);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after stall instr", int'(instr_out), 9'h078);
    checkOutput("after stall pc_out", int'(pc_out), 7);

    // start while running is ignored; halt under stall is held off.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("start in run instr", int'(instr_out), 9'h089);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("halt+stall halted", int'(halted), 0);
    checkOutput("halt+stall instr", int'(instr_out), 9'h089);

    // Branch wins over halt_dec in the same cycle.
    applyStimulus(0, 1, 0, 1, 8'h10);
    checkOutput("halt+branch halted", int'(halted), 0);
    checkOutput("halt+branch imem_addr", int'(imem_addr), 8'h10);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("branch 0x10 instr", int'(instr_out), 9'h111);

    // Halt alone, then counter holds while halted.
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("halt halted", int'(halted), 1);
    checkOutput("halt valid", int'(instr_valid), 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("halted cycle_count", int'(cycle_count), 17);
    checkOutput("halted imem_addr", int'(imem_addr), 0);

    // Restart from 0 with a cleared counter.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart halted", int'(halted), 0);
    checkOutput("restart cycle_count", int'(cycle_count), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart instr", int'(instr_out), 9'h001);

    // PC wraps from 0xFF to 0x00.
    applyStimulus(0, 0, 0, 1, 8'hFE);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap pc_out FE", int'(pc_out), 8'hFE);
    checkOutput("wrap instr FE", int'(instr_out), 9'h0DF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap pc_out FF", int'(pc_out), 8'hFF);
    checkOutput("wrap instr FF", int'(instr_out), 9'h0F0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap pc_out 00", int'(pc_out), 0);
    checkOutput("wrap imem_addr", int'(imem_addr), 1);

    // Asynchronous reset mid-run, checked before the next clock edge.
    rst_n = 1'b0;
    #1;
    checkOutput("async rst instr", int'(instr_out), 9'h1B0);
    checkOutput("async rst pc_out", int'(pc_out), 0);
    checkOutput("async rst valid", int'(instr_valid), 0);
    checkOutput("async rst imem_addr", int'(imem_addr), 0);
    checkOutput("async rst cycle_count", int'(cycle_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post rst stays idle", int'(instr_valid), 0);
    checkOutput("post rst imem_addr", int'(imem_addr), 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
